bch_early_stop_ctrl: RTL

Parametrised early-termination controller for the BCH/Chase decoder. It collects syndrome sets for up to NUM_TP test patterns, arriving one pattern per cycle in any order. It fires a one-cycle early-stop pulse, with the winning pattern index, as soon as a qualifying all-zero syndrome set arrives. If no qualifying set arrives, it fires a decode-request pulse once all required patterns are seen. It sits between the syndrome calculators and the Berlekamp–Massey/Chien stages, and replaces the fixed 4-pattern, wait-for-all early-stop check.

---
 rtl/bch_early_stop_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/bch_early_stop_ctrl.sv
// Early-termination controller for the BCH/Chase decoder: collects per-pattern
// syndrome sets and decides between an early stop and a full decode request.
module bch_early_stop_ctrl #(
  parameter int NUM_TP  = 4,
  parameter int NUM_SYN = 4,
  parameter int SYN_W   = 10,
  parameter int TP_W    = (NUM_TP > 1) ? $clog2(NUM_TP) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_mode,
  input  logic [1:0]               i_code,
  input  logic                     i_syn_valid,
  input  logic [TP_W-1:0]          i_tp_idx,
  input  logic [NUM_SYN*SYN_W-1:0] i_syn,
  output logic                     o_busy,
  output logic                     o_early_stop_pulse,
  output logic                     o_decode_req_pulse,
  output logic [TP_W-1:0]          o_stop_tp_idx,
  output logic                     o_dup_err
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_e;

  state_e            state_q, state_d;
  logic [NUM_TP-1:0] seen_q, seen_d;
  logic              mode_q, mode_d;
  logic              fullCheck_q, fullCheck_d;
  logic              earlyStop_q, earlyStop_d;
  logic              decodeReq_q, decodeReq_d;
  logic [TP_W-1:0]   stopIdx_q, stopIdx_d;
  logic              dupErr_q, dupErr_d;

  logic [NUM_TP-1:0] hitVec;
  logic              effFull;
  logic              synZero;
  logic              accept;

  // One-hot of the incoming index; out-of-range indices give an empty vector.
  always_comb begin
    hitVec = '0;
    for (int i = 0; i < NUM_TP; i++) begin
      if (i_tp_idx == TP_W'(i)) hitVec[i] = 1'b1;
    end
  end

  // A start in the same cycle means the new code applies to this input.
  always_comb begin
    effFull = i_start ? (i_code == 2'b10) : fullCheck_q;
    synZero = 1'b1;
    for (int k = 0; k < NUM_SYN; k++) begin
      if (((k < NUM_SYN / 2) || effFull) && (i_syn[k*SYN_W +: SYN_W] != '0)) synZero = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    seen_d      = seen_q;
    mode_d      = mode_q;
    fullCheck_d = fullCheck_q;
    earlyStop_d = 1'b0;
    decodeReq_d = 1'b0;
    stopIdx_d   = stopIdx_q;
    dupErr_d    = dupErr_q;
    accept      = 1'b0;

    if (i_start) begin
      state_d     = COLLECT;
      seen_d      = '0;
      mode_d      = i_mode;
      fullCheck_d = (i_code == 2'b10);
      stopIdx_d   = '0;
      dupErr_d    = 1'b0;
    end

    accept = (i_start || (state_q == COLLECT)) && i_syn_valid && (|hitVec)
             && (mode_d || (i_tp_idx == '0));

    if (accept) begin
      if (|(seen_d & hitVec)) begin
        dupErr_d = 1'b1;
      end else begin
        seen_d = seen_d | hitVec;
        if (synZero) begin
          earlyStop_d = 1'b1;
          stopIdx_d   = i_tp_idx;
          state_d     = DONE;
        end else if (mode_d ? (&seen_d) : seen_d[0]) begin
          decodeReq_d = 1'b1;
          state_d     = DONE;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      seen_q      <= '0;
      mode_q      <= 1'b0;
      fullCheck_q <= 1'b0;
      earlyStop_q <= 1'b0;
      decodeReq_q <= 1'b0;
      stopIdx_q   <= '0;
      dupErr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      seen_q      <= seen_d;
      mode_q      <= mode_d;
      fullCheck_q <= fullCheck_d;
      earlyStop_q <= earlyStop_d;
      decodeReq_q <= decodeReq_d;
      stopIdx_q   <= stopIdx_d;
      dupErr_q    <= dupErr_d;
    end
  end

  assign o_busy             = (state_q == COLLECT);
  assign o_early_stop_pulse = earlyStop_q;
  assign o_decode_req_pulse = decodeReq_q;
  assign o_stop_tp_idx      = stopIdx_q;
  assign o_dup_err          = dupErr_q;

endmodule
